// File: rtl/fft_pkg.sv
// Shared definitions for the 8-point streaming FFT: sizes, FSM states,
// the Q15 twiddle table and the bit-reverse helper used by the loader.
package fft_pkg;

  localparam int DW    = 16;
  localparam int N     = 8;
  localparam int LOG2N = 3;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_CALC = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // W8^e for e = 0..3, Q15
  localparam logic [DW-1:0] TW_RE [4] = '{16'h7FFF, 16'h5A82, 16'h0000, 16'hA57E};
  localparam logic [DW-1:0] TW_IM [4] = '{16'h0000, 16'hA57E, 16'h8001, 16'hA57E};

  function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] n);
    return {n[0], n[1], n[2]};
  endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Combinational radix-2 DIT butterfly with 1/2 scaling: a' = (a+t)/2, b' = (a-t)/2,
// where t = b * W8^tw and W8^0 bypasses the multiplier.
module fft_butterfly
  import fft_pkg::*;
(
  input  logic [DW-1:0] i_a_re,
  input  logic [DW-1:0] i_a_im,
  input  logic [DW-1:0] i_b_re,
  input  logic [DW-1:0] i_b_im,
  input  logic [1:0]    i_tw,
  output logic [DW-1:0] o_a_re,
  output logic [DW-1:0] o_a_im,
  output logic [DW-1:0] o_b_re,
  output logic [DW-1:0] o_b_im
);

  logic signed [2*DW:0] w_bre_x, w_bim_x, w_wre_x, w_wim_x;
  logic signed [2*DW:0] w_prod_re, w_prod_im;
  logic signed [DW+1:0] w_t_re, w_t_im;
  logic signed [DW+2:0] w_sum_re, w_sum_im, w_dif_re, w_dif_im;

  // Complex twiddle multiply, then the scaled sum and difference
  always_comb begin
    w_bre_x   = {{(DW+1){i_b_re[DW-1]}}, i_b_re};
    w_bim_x   = {{(DW+1){i_b_im[DW-1]}}, i_b_im};
    w_wre_x   = {{(DW+1){TW_RE[i_tw][DW-1]}}, TW_RE[i_tw]};
    w_wim_x   = {{(DW+1){TW_IM[i_tw][DW-1]}}, TW_IM[i_tw]};
    w_prod_re = w_bre_x * w_wre_x - w_bim_x * w_wim_x;
    w_prod_im = w_bre_x * w_wim_x + w_bim_x * w_wre_x;
    if (i_tw == 2'd0) begin
      w_t_re = {{2{i_b_re[DW-1]}}, i_b_re};
      w_t_im = {{2{i_b_im[DW-1]}}, i_b_im};
    end else begin
      w_t_re = (DW+2)'(w_prod_re >>> 15);
      w_t_im = (DW+2)'(w_prod_im >>> 15);
    end
    w_sum_re = {{3{i_a_re[DW-1]}}, i_a_re} + {w_t_re[DW+1], w_t_re};
    w_sum_im = {{3{i_a_im[DW-1]}}, i_a_im} + {w_t_im[DW+1], w_t_im};
    w_dif_re = {{3{i_a_re[DW-1]}}, i_a_re} - {w_t_re[DW+1], w_t_re};
    w_dif_im = {{3{i_a_im[DW-1]}}, i_a_im} - {w_t_im[DW+1], w_t_im};
    o_a_re   = DW'(w_sum_re >>> 1);
    o_a_im   = DW'(w_sum_im >>> 1);
    o_b_re   = DW'(w_dif_re >>> 1);
    o_b_im   = DW'(w_dif_im >>> 1);
  end

endmodule

// File: rtl/fft_top_stream.sv
// Streaming 8-point real-input FFT: load 8 samples in bit-reversed order,
// run 12 in-place butterflies (one per cycle), then emit bins 0..7 serially.
module fft_top_stream
  import fft_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          req_i,
  input  logic [DW-1:0] data_i,
  output logic          ready_o,
  output logic          dout_valid_o,
  output logic [2:0]    dout_idx_o,
  output logic [DW-1:0] dout_re_o,
  output logic [DW-1:0] dout_im_o
);

  logic [DW-1:0]    r_buf_re [N];
  logic [DW-1:0]    r_buf_im [N];
  state_e           r_state, w_state_nxt;
  logic [LOG2N-1:0] r_cnt;
  logic [1:0]       r_stage, r_bfly;
  logic             r_valid;
  logic [2:0]       r_idx;
  logic [DW-1:0]    r_re, r_im;
  logic             w_accept;
  logic [2:0]       w_ia, w_ib;
  logic [1:0]       w_tw;
  logic [DW-1:0]    w_na_re, w_na_im, w_nb_re, w_nb_im;

  assign w_accept     = req_i && (r_state == ST_LOAD);
  assign ready_o      = (r_state == ST_LOAD);
  assign dout_valid_o = r_valid;
  assign dout_idx_o   = r_idx;
  assign dout_re_o    = r_re;
  assign dout_im_o    = r_im;

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD: if (w_accept && r_cnt == 3'd7) w_state_nxt = ST_CALC;
               else                           w_state_nxt = ST_LOAD;
      ST_CALC: if (r_stage == 2'd2 && r_bfly == 2'd3) w_state_nxt = ST_OUT;
               else                                   w_state_nxt = ST_CALC;
      ST_OUT:  if (r_cnt == 3'd7) w_state_nxt = ST_LOAD;
               else               w_state_nxt = ST_OUT;
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  // Butterfly addresses: a at i, b at i + 2^stage, twiddle j*(4>>stage)
  always_comb begin
    w_ia = 3'd0;
    w_ib = 3'd0;
    w_tw = 2'd0;
    case (r_stage)
      2'd0:    begin w_ia = {r_bfly, 1'b0};               w_ib = {r_bfly, 1'b1};               w_tw = 2'd0;              end
      2'd1:    begin w_ia = {r_bfly[1], 1'b0, r_bfly[0]}; w_ib = {r_bfly[1], 1'b1, r_bfly[0]}; w_tw = {r_bfly[0], 1'b0}; end
      2'd2:    begin w_ia = {1'b0, r_bfly};               w_ib = {1'b1, r_bfly};               w_tw = r_bfly;            end
      default: begin w_ia = 3'd0;                         w_ib = 3'd0;                         w_tw = 2'd0;              end
    endcase
  end

  fft_butterfly u_bfly (
    .i_a_re (r_buf_re[w_ia]),
    .i_a_im (r_buf_im[w_ia]),
    .i_b_re (r_buf_re[w_ib]),
    .i_b_im (r_buf_im[w_ib]),
    .i_tw   (w_tw),
    .o_a_re (w_na_re),
    .o_a_im (w_na_im),
    .o_b_re (w_nb_re),
    .o_b_im (w_nb_im)
  );

  // State and counters
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_LOAD;
      r_cnt   <= 3'd0;
      r_stage <= 2'd0;
      r_bfly  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_LOAD: if (w_accept) r_cnt <= r_cnt + 3'd1;
        ST_CALC: begin
          r_bfly <= r_bfly + 2'd1;
          if (r_bfly == 2'd3) r_stage <= (r_stage == 2'd2) ? 2'd0 : r_stage + 2'd1;
        end
        ST_OUT:  r_cnt <= r_cnt + 3'd1;
        default: r_cnt <= 3'd0;
      endcase
    end
  end

  // Sample buffer: bit-reversed load, in-place butterfly write-back (contents not reset)
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf_re[bitrev3(r_cnt)] <= data_i;
      r_buf_im[bitrev3(r_cnt)] <= 16'h0000;
    end else if (r_state == ST_CALC) begin
      r_buf_re[w_ia] <= w_na_re;
      r_buf_im[w_ia] <= w_na_im;
      r_buf_re[w_ib] <= w_nb_re;
      r_buf_im[w_ib] <= w_nb_im;
    end
  end

  // Registered output port
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_idx   <= 3'd0;
      r_re    <= 16'h0000;
      r_im    <= 16'h0000;
    end else if (r_state == ST_OUT) begin
      r_valid <= 1'b1;
      r_idx   <= r_cnt;
      r_re    <= r_buf_re[r_cnt];
      r_im    <= r_buf_im[r_cnt];
    end else begin
      r_valid <= 1'b0;
      r_idx   <= 3'd0;
      r_re    <= 16'h0000;
      r_im    <= 16'h0000;
    end
  end

endmodule

// File: tb/tb_fft_top_stream.sv
// Self-checking bench for fft_top_stream: directed and random frames compared
// against an arithmetic reference FFT kept in the bench.
module tb_fft_top_stream;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_i;
  logic [15:0] data_i;
  logic        ready_o;
  logic        dout_valid_o;
  logic [2:0]  dout_idx_o;
  logic [15:0] dout_re_o;
  logic [15:0] dout_im_o;

  int n_checks = 0;
  int n_pass   = 0;
  int frm    [8];
  int exp_re [8];
  int exp_im [8];

  always #5 clk = ~clk;

  fft_top_stream dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_i        (req_i),
    .data_i       (data_i),
    .ready_o      (ready_o),
    .dout_valid_o (dout_valid_o),
    .dout_idx_o   (dout_idx_o),
    .dout_re_o    (dout_re_o),
    .dout_im_o    (dout_im_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  function automatic int wrap16(input longint v);
    logic [15:0] t;
    t = v[15:0];
    return int'($signed(t));
  endfunction

  // Reference: textbook iterative DIT FFT with per-stage halving on plain integers
  function automatic void ref_fft();
    int     re [8];
    int     im [8];
    int     wr [4] = '{32767, 23170, 0, -23170};
    int     wi [4] = '{0, -23170, -32767, -23170};
    longint tr, ti, ar, ai;
    for (int n = 0; n < 8; n++) begin
      int r;
      r = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
      re[r] = frm[n];
      im[r] = 0;
    end
    for (int s = 0; s < 3; s++) begin
      int h;
      h = 1 << s;
      for (int g = 0; g < 8; g += 2 * h) begin
        for (int j = 0; j < h; j++) begin
          int ia, ib, e;
          ia = g + j;
          ib = ia + h;
          e  = j * (4 >> s);
          if (e == 0) begin
            tr = re[ib];
            ti = im[ib];
          end else begin
            tr = (longint'(re[ib]) * wr[e] - longint'(im[ib]) * wi[e]) >>> 15;
            ti = (longint'(re[ib]) * wi[e] + longint'(im[ib]) * wr[e]) >>> 15;
          end
          ar = re[ia];
          ai = im[ia];
          re[ia] = wrap16((ar + tr) >>> 1);
          im[ia] = wrap16((ai + ti) >>> 1);
          re[ib] = wrap16((ar - tr) >>> 1);
          im[ib] = wrap16((ai - ti) >>> 1);
        end
      end
    end
    for (int k = 0; k < 8; k++) begin
      exp_re[k] = re[k];
      exp_im[k] = im[k];
    end
  endfunction

  function automatic void rand_frame();
    logic [15:0] r16;
    for (int n = 0; n < 8; n++) begin
      r16 = 16'($urandom);
      frm[n] = int'($signed(r16));
    end
  endfunction

  // Feed frm[0..7]; with gaps, req_i alternates 1,0,1,0 and idle cycles carry junk data
  task automatic send_frame(input bit gaps);
    int n = 0;
    int guard = 0;
    bit tog = 1'b0;
    bit acc;
    while (n < 8 && guard < 100) begin
      guard++;
      tog    = gaps ? ~tog : 1'b1;
      req_i  = tog;
      data_i = tog ? 16'(frm[n]) : 16'($urandom);
      acc    = req_i && ready_o;
      @(posedge clk); #1;
      if (acc) n++;
    end
    chk("load_count", n, 8);
    chk("ready_drop", {31'd0, ready_o}, 32'd0);
  endtask

  // Wait for the first bin (bounded) and check all 8; returns with bin 7 visible
  task automatic collect(input bit noisy);
    int lat = 0;
    ref_fft();
    while (!dout_valid_o && lat < 60) begin
      req_i  = noisy;
      data_i = 16'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 13);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("valid[%0d]", k), {31'd0, dout_valid_o}, 32'd1);
      chk($sformatf("idx[%0d]", k), {29'd0, dout_idx_o}, k);
      chk($sformatf("re[%0d]", k), {16'd0, dout_re_o}, {16'd0, 16'(exp_re[k])});
      chk($sformatf("im[%0d]", k), {16'd0, dout_im_o}, {16'd0, 16'(exp_im[k])});
      chk($sformatf("ready_out[%0d]", k), {31'd0, ready_o}, (k == 7) ? 32'd1 : 32'd0);
      if (k < 7) begin
        req_i  = noisy;
        data_i = 16'($urandom);
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    int lat;
    rstn   = 1'b0;
    req_i  = 1'b0;
    data_i = 16'h0000;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_valid", {31'd0, dout_valid_o}, 32'd0);
    chk("rst_idx", {29'd0, dout_idx_o}, 32'd0);
    chk("rst_re", {16'd0, dout_re_o}, 32'd0);
    chk("rst_im", {16'd0, dout_im_o}, 32'd0);
    rstn = 1'b1;

    // DC full scale, two back-to-back frames with req_i held high
    for (int n = 0; n < 8; n++) frm[n] = 32767;
    send_frame(1'b0);
    collect(1'b1);
    send_frame(1'b0);
    collect(1'b1);
    chk("dc_bin0", exp_re[0], 32767);

    // Impulse
    for (int n = 0; n < 8; n++) frm[n] = (n == 0) ? 32767 : 0;
    send_frame(1'b0);
    collect(1'b0);
    chk("imp_bin5", exp_re[5], 32'h0FFF);

    // Alternating +/- half scale
    for (int n = 0; n < 8; n++) frm[n] = (n % 2 == 0) ? 16384 : -16384;
    send_frame(1'b0);
    collect(1'b0);
    chk("alt_bin4", exp_re[4], 32'h4000);

    // All zeros, then valid must drop after exactly 8 bins
    for (int n = 0; n < 8; n++) frm[n] = 0;
    send_frame(1'b0);
    collect(1'b0);
    req_i = 1'b0;
    @(posedge clk); #1;
    chk("valid_end", {31'd0, dout_valid_o}, 32'd0);

    // Most-negative input everywhere
    for (int n = 0; n < 8; n++) frm[n] = -32768;
    send_frame(1'b0);
    collect(1'b1);

    // Gapped load, then random frames with mixed gaps and noise in CALC/OUT
    rand_frame();
    send_frame(1'b1);
    collect(1'b1);
    for (int f = 0; f < 6; f++) begin
      rand_frame();
      send_frame(1'($urandom_range(0, 1)));
      collect(1'($urandom_range(0, 1)));
    end

    // Reset in the middle of the output burst
    req_i = 1'b0;
    @(posedge clk); #1;
    rand_frame();
    send_frame(1'b0);
    lat = 0;
    while (!dout_valid_o && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("mid_latency", lat, 13);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", {31'd0, dout_valid_o}, 32'd0);
    chk("midrst_ready", {31'd0, ready_o}, 32'd1);
    rstn = 1'b1;
    rand_frame();
    send_frame(1'b0);
    collect(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
